decode_issue_stage: RTL
=======================

// Module: decode_issue_stage
// PURPOSE
//  Upstream neighbour of the execute stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake.
//  Reads an 8x32 register file and registers src1/src2/imm/control_in/enable_ex into the execute stage.
//  Takes write-back from the ALU/memory path. Inserts a one-cycle bubble on a load-use hazard.
// PARAMETERS
//  N        32      datapath width (matches `N)
//  C        7       control field width (matches `C)
//  RA       3       register address width; register file depth = 2**RA
//  LOAD_OP  3'b101  control[2:0] value marking a memory-read (load) instruction
// PORTS
//  clock        in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  instr        in   N   {control[31:25], rd[24:22], rs1[21:19], rs2[18:16], imm16[15:0]}
//  instr_valid  in   1   instr holds a valid instruction this cycle
//  instr_ready  out  1   stage accepts instr this cycle (combinational, = !stall)
//  wb_en        in   1   register-file write enable from write-back
//  wb_addr      in   RA  write-back destination
//  wb_data      in   N   write-back data
//  src1         out  N   registered operand 1 to execute
//  src2         out  N   registered operand 2 to execute
//  imm          out  N   registered sign-extended imm16
//  control_in   out  C   registered control field
//  rd_out       out  RA  registered destination, travels with the instruction
//  enable_ex    out  1   registered: outputs carry a valid instruction
// BEHAVIOUR
//  Reset:
//   - Clock and reset exactly as decided: one clock `clock`; `reset` synchronous, active-high.
//   - On reset, all outputs and registers go to 0, FSM goes to RUN, and the register file is cleared to 0.
//  Register file:
//   - r0 reads 0 always; writes to r0 are ignored.
//   - Write occurs on the clock edge when wb_en=1.
//   - Same-cycle read of wb_addr (nonzero) returns wb_data (write-first bypass).
//  Issue:
//   - Condition: instr_valid && instr_ready.
//   - Next edge: src1=rf[rs1], src2=rf[rs2], imm={{16{imm16[15]}},imm16}, control_in=instr[31:25], rd_out=rd, enable_ex=1.
//   - Otherwise enable_ex=0 next edge. Datapath outputs hold their last value; execute must ignore them when enable_ex=0.
//  Latency:
//   - Exactly 1 cycle from accepted instr to enable_ex=1.
//   - Throughput is 1 instruction/cycle absent hazards.
//  Hazard FSM, states RUN and STALL:
//   - load_in_ex = enable_ex && control_in[2:0]==LOAD_OP && rd_out!=0.
//   - hazard = instr_valid && load_in_ex && (rs1==rd_out || rs2==rd_out).
//   - RUN: hazard -> STALL. Mark instr_ready=0 this cycle; bubble (enable_ex=0) next edge.
//   - STALL: instr_ready=1 and issue normally, reading the register file with bypass, then return to RUN.
//   - The STALL cycle clears load_in_ex, so back-to-back stalls never exceed 1 cycle per load.
//   - rs2 counts toward the hazard even for immediate-form ops (conservative).
//  Boundaries:
//   - instr_valid=0 in STALL: still return to RUN, enable_ex=0.
//   - wb_en to the register being read during the stall cycle: bypass supplies the new value.
//   - Reset mid-stall: RUN, enable_ex=0 on the next edge, and the pending instruction is dropped.
//   - Upstream must hold instr stable while instr_valid && !instr_ready.
// STRUCTURE
//  Shared package proc_pkg:
//   - N/C/RA constants.
//   - instr_t packed struct of the field layout.
//   - opselect enum including LOAD_OP.
//   - Shared with the execute and ALU stages.
//  One sub-module: regfile_2r1w (2 async read ports, 1 sync write, r0 tied to 0, write-first bypass).
//  Hazard FSM and pipeline registers live in the top level.
// TESTING
//  - Reset: assert reset 2 cycles with instr_valid=1 -> enable_ex=0, all outputs 0, instr_ready=1 after release.
//  - Sign-extend: instr with imm16=16'h8001, rs1=r2 holding 5 -> next cycle enable_ex=1, imm=32'hFFFF8001, src1=5.
//  - Bypass: wb_en=1, wb_addr=3, wb_data=32'hDEAD same cycle as instr reading rs1=3 -> src1=32'hDEAD.
//  - r0: wb_en=1, wb_addr=0, wb_data=7, then read rs1=0 -> src1=0.
//  - Load-use: a load to r4, then an instr with rs2=4 -> instr_ready=0 one cycle, one bubble (enable_ex=0).
//    The dependent instr then issues with src2 = write-back value delivered during the stall.
//  - No false stall: a load to r4, then an instr with rs1=r5 and rs2=r6 -> back-to-back enable_ex=1, no bubble.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared pipeline definitions: widths, instruction field layout and control encodings.
package proc_pkg;
    localparam int N  = 32;
    localparam int C  = 7;
    localparam int RA = 3;

    typedef struct packed {
        logic [C-1:0]  control;
        logic [RA-1:0] rd;
        logic [RA-1:0] rs1;
        logic [RA-1:0] rs2;
        logic [15:0]   imm16;
    } instr_t;

    // Low three control bits select the operation class.
    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_LOAD  = 3'b101,
        OP_STORE = 3'b110,
        OP_SHIFT = 3'b111
    } opselect_e;

    localparam logic [2:0] LOAD_OP = OP_LOAD;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;
endpackage

// File: rtl/regfile_2r1w.sv
// Two async read ports, one sync write port; r0 reads zero, writes bypass to same-cycle reads.
module regfile_2r1w #(
    parameter int N  = 32,
    parameter int RA = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we_i,
    input  logic [RA-1:0]          waddr_i,
    input  logic [N-1:0]           wdata_i,
    input  logic [1:0][RA-1:0]     raddr_i,
    output logic [1:0][N-1:0]      rdata_o
);
    localparam int DEPTH = 1 << RA;

    logic [DEPTH-1:0][N-1:0] mem_q;

    always_ff @(posedge clock) begin
        if (reset)
            mem_q <= '0;
        else if (we_i && waddr_i != '0)
            mem_q[waddr_i] <= wdata_i;
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rdata_o[p] = (raddr_i[p] == '0)                 ? '0      :
                            (we_i && waddr_i == raddr_i[p])    ? wdata_i :
                                                                 mem_q[raddr_i[p]];
    end
endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue: reads operands, registers them into execute, and inserts one bubble on load-use.
module decode_issue_stage
    import proc_pkg::*;
#(
    parameter int         N       = proc_pkg::N,
    parameter int         C       = proc_pkg::C,
    parameter int         RA      = proc_pkg::RA,
    parameter logic [2:0] LOAD_OP = proc_pkg::LOAD_OP
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          wb_en,
    input  logic [RA-1:0] wb_addr,
    input  logic [N-1:0]  wb_data,
    output logic [N-1:0]  src1,
    output logic [N-1:0]  src2,
    output logic [N-1:0]  imm,
    output logic [C-1:0]  control_in,
    output logic [RA-1:0] rd_out,
    output logic          enable_ex
);
    instr_t               in_s;
    logic [1:0][N-1:0]    rdata;
    hz_state_e            state_q, state_d;
    logic                 load_in_ex, hazard, issue;
    logic [N-1:0]         src1_q, src2_q, imm_q;
    logic [C-1:0]         ctrl_q;
    logic [RA-1:0]        rd_q;
    logic                 en_q;

    assign in_s = instr_t'(instr);

    regfile_2r1w #(.N(N), .RA(RA)) u_rf (
        .clock   (clock),
        .reset   (reset),
        .we_i    (wb_en),
        .waddr_i (wb_addr),
        .wdata_i (wb_data),
        .raddr_i ({in_s.rs2, in_s.rs1}),
        .rdata_o (rdata)
    );

    // rs2 always participates, even for immediate-form ops.
    assign load_in_ex = en_q && ctrl_q[2:0] == LOAD_OP && rd_q != '0;
    assign hazard     = instr_valid && load_in_ex && (in_s.rs1 == rd_q || in_s.rs2 == rd_q);

    always_ff @(posedge clock) begin
        if (reset) state_q <= HZ_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_RUN:   if (hazard) state_d = HZ_STALL;
            HZ_STALL: state_d = HZ_RUN;
            default:  state_d = HZ_RUN;
        endcase
    end

    always_comb begin
        instr_ready = 1'b1;
        if (state_q == HZ_RUN && hazard) instr_ready = 1'b0;
    end

    assign issue = instr_valid && instr_ready;

    // Datapath registers hold while idle; execute qualifies them with enable_ex.
    always_ff @(posedge clock) begin
        if (reset) begin
            src1_q <= '0;
            src2_q <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
            rd_q   <= '0;
            en_q   <= 1'b0;
        end else begin
            en_q <= issue;
            if (issue) begin
                src1_q <= rdata[0];
                src2_q <= rdata[1];
                imm_q  <= {{(N-16){in_s.imm16[15]}}, in_s.imm16};
                ctrl_q <= in_s.control;
                rd_q   <= in_s.rd;
            end
        end
    end

    assign src1       = src1_q;
    assign src2       = src2_q;
    assign imm        = imm_q;
    assign control_in = ctrl_q;
    assign rd_out     = rd_q;
    assign enable_ex  = en_q;
endmodule
